mul_mdc_out_tiler: RTL and testbench
====================================

# mul_mdc_out_tiler

Output-side stage placed directly downstream of the mul_mdc kernel adapter: it consumes the kernel result stream `d`, buffers it in a 2-entry FIFO and forwards it to the output streamer. It counts beats against a per-tile length, stops accepting once the tile is complete, and emits a single-cycle tile-done pulse when the last beat has left the block. The controller uses this pulse, rather than per-beat done, to advance its loops.

## Interface
Parameters:
- `DATA_WIDTH`, default 32: width of the stream data.
- `CNT_WIDTH`, default 16: width of the length and counter fields; matches `reg_len`.

Ports:
- `clk_i`, input, 1: clock.
- `rst_ni`, input, 1: reset, asynchronous, active-low.
- `clear_i`, input, 1: synchronous soft clear.
- `start_i`, input, 1: single-cycle tile start; latches `len_i`.
- `len_i`, input, CNT_WIDTH: tile length in beats.
- `d_i`, sink, `hwpe_stream_intf_stream` (DATA_WIDTH): kernel result stream (`data`/`valid`/`ready`).
- `d_o`, source, `hwpe_stream_intf_stream` (DATA_WIDTH): stream to the output streamer.
- `tile_done_o`, output, 1: single-cycle pulse at tile completion.
- `busy_o`, output, 1: high in every state except IDLE.
- `beat_cnt_o`, output, CNT_WIDTH: number of beats emitted on `d_o` in the current tile.
- `err_o`, output, 1: sticky protocol-error flag.

## Operation
- **FSM states:** IDLE, RUN, DRAIN, DONE.
- **IDLE:**
  - `d_i.ready` = 0.
  - `start_i` with `len_i` != 0: latch the length, clear `in_cnt` and `beat_cnt_o`, go to RUN.
  - `start_i` with `len_i` == 0: go directly to DONE; no beats are transferred.
- **RUN:**
  - `d_i.ready` = (fifo_count < 2) & (in_cnt < len).
  - Each handshake on `d_i` pushes one entry and increments `in_cnt`.
  - When an accepted beat makes `in_cnt` == len, go to DRAIN on the next edge.
- **DRAIN:**
  - `d_i.ready` = 0.
  - Go to DONE when `beat_cnt_o` == len and the FIFO is empty.
- **DONE:** `tile_done_o` = 1 for exactly one cycle, then return to IDLE.
- **FIFO:** 2 entries, pointer-based, with registered head data.
  - `d_o.valid` = FIFO non-empty. `d_o.data` = head entry.
  - Each handshake on `d_o` pops one entry and increments `beat_cnt_o`.
  - A push and a pop in the same cycle leave the count unchanged.
- **Counters:** `CNT_WIDTH` bits, unsigned, no wrap. `in_cnt` never exceeds len by construction.
- **`start_i` while `busy_o`:** ignored; sets `err_o`.
- **`d_i.valid` in IDLE or DRAIN:** no transfer occurs (ready is low); the beat is held upstream. This is not an error.
- **`clear_i`:**
  - Returns the FSM to IDLE and flushes the FIFO.
  - Zeroes `in_cnt`, `beat_cnt_o` and `err_o`.
  - Takes priority over `start_i` in the same cycle.
- **Reset values:** FSM in IDLE. `d_o.valid` = 0, `d_i.ready` = 0, `tile_done_o` = 0, `busy_o` = 0, `beat_cnt_o` = 0, `err_o` = 0, FIFO empty.

## Timing
- **Latency:** a beat accepted on `d_i` at edge t is valid on `d_o` from cycle t+1.
- **Throughput:** one beat per cycle when `d_o.ready` is held high.
- **`d_o` stability:** `d_o.valid` and `d_o.data` stay stable while `d_o.valid & !d_o.ready`, and do not depend combinationally on `d_o.ready`.
- **`d_i.ready` dependencies:** depends only on registered state (FSM, `fifo_count`, `in_cnt`); there is no combinational path from `d_o.ready`.
- **Pulse timing:** `tile_done_o` asserts in the cycle after the final `d_o` handshake. For `len_i` == 0 it asserts in the cycle after `start_i`.
- **Back-to-back tiles:** a `start_i` is accepted in the cycle after DONE (i.e. in IDLE). Minimum tile overhead is 2 cycles (start→RUN, DONE).
- **Reset mid-tile:** an asynchronous reset drops all outputs immediately. In-flight beats are discarded.

## Configuration
- Macro: `MUL_MDC_OUT_TILER_LAST_EN`.
- **Defined:**
  - An extra output `last_o` (1 bit) is present.
  - It is high while `d_o.valid` and the head entry is beat number len-1 of the tile, tracked via a per-entry last bit stored in the FIFO.
  - `last_o` is 0 at reset and after `clear_i`.
- **Undefined:** the `last_o` port and the per-entry last bits are absent. All other behaviour is identical.

## Test plan
- **Basic tile:** `len_i`=4, `d_i` streams 0x11,0x22,0x33,0x44 with `d_o.ready`=1.
  - Expect `d_o` to emit the same data one cycle later.
  - Expect `beat_cnt_o`=4 and a single `tile_done_o` one cycle after the 4th output.
  - Expect `d_i.ready`=0 after the 4th input.
- **Backpressure:** `len_i`=3 with `d_o.ready` low for 5 cycles.
  - Expect the FIFO to hold 2 beats, `d_i.ready`=0, and `d_o.data` stable.
  - On release, expect all 3 beats in order and `tile_done_o` after the 3rd.
- **Zero length:** `len_i`=0 → expect `tile_done_o` in the cycle after `start_i`, no `d_i` handshake, and `busy_o` high for exactly 1 cycle.
- **Start while busy:** `start_i` during RUN with `len_i`=8 → expect it to be ignored, the tile to complete with the original length, and `err_o`=1.
  - A subsequent `clear_i` returns `err_o` to 0.
- **Clear and reset mid-tile:**
  - `clear_i` after 2 of 6 beats → expect IDLE, FIFO empty, `d_o.valid`=0, `beat_cnt_o`=0. A fresh tile with `len_i`=2 then completes normally.
  - Repeat with `rst_ni` low for 1 cycle → expect the reset values asynchronously.
- **With `MUL_MDC_OUT_TILER_LAST_EN`:** `len_i`=3 → expect `last_o`=1 only during the 3rd `d_o` beat, including when that beat is stalled for 2 cycles.

Source files
------------

// File: rtl/mul_mdc_out_tiler.sv
// Output tiler for the mul_mdc kernel: buffers result beats in a 2-entry FIFO and emits a tile-done pulse
// once len beats have left. Optional macro MUL_MDC_OUT_TILER_LAST_EN adds a per-beat last_o flag.
module mul_mdc_out_tiler #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned CNT_WIDTH  = 16
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  clear_i,
    input  logic                  start_i,
    input  logic [CNT_WIDTH-1:0]  len_i,
    input  logic [DATA_WIDTH-1:0] d_i_data,
    input  logic                  d_i_valid,
    output logic                  d_i_ready,
    output logic [DATA_WIDTH-1:0] d_o_data,
    output logic                  d_o_valid,
    input  logic                  d_o_ready,
    output logic                  tile_done_o,
    output logic                  busy_o,
    output logic [CNT_WIDTH-1:0]  beat_cnt_o,
`ifdef MUL_MDC_OUT_TILER_LAST_EN
    output logic                  last_o,
`endif
    output logic                  err_o
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_e;

    localparam logic [CNT_WIDTH-1:0] CNT_ZERO = {CNT_WIDTH{1'b0}};
    localparam logic [CNT_WIDTH-1:0] CNT_ONE  = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

    state_e                 state_q, state_d;
    logic [CNT_WIDTH-1:0]   len_q, len_d;
    logic [CNT_WIDTH-1:0]   in_cnt_q, in_cnt_d;
    logic [CNT_WIDTH-1:0]   beat_cnt_q, beat_cnt_d;
    logic                   err_q, err_d;
    logic [DATA_WIDTH-1:0]  mem_q [2];
    logic [DATA_WIDTH-1:0]  mem_d [2];
    logic                   wr_ptr_q, wr_ptr_d;
    logic                   rd_ptr_q, rd_ptr_d;
    logic [1:0]             fifo_cnt_q, fifo_cnt_d;
`ifdef MUL_MDC_OUT_TILER_LAST_EN
    logic                   last_q [2];
    logic                   last_d [2];
`endif

    logic                   in_ready_s;
    logic                   out_valid_s;
    logic                   push_s;
    logic                   pop_s;
    logic                   final_in_s;

    // Handshake qualifiers; ready and valid come only from registered state
    always_comb begin
        push_s     = d_i_valid & in_ready_s;
        pop_s      = out_valid_s & d_o_ready;
        final_in_s = ((in_cnt_q + CNT_ONE) == len_q);
    end

    // State register and all datapath flops
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= IDLE;
            len_q      <= CNT_ZERO;
            in_cnt_q   <= CNT_ZERO;
            beat_cnt_q <= CNT_ZERO;
            err_q      <= 1'b0;
            mem_q[0]   <= {DATA_WIDTH{1'b0}};
            mem_q[1]   <= {DATA_WIDTH{1'b0}};
            wr_ptr_q   <= 1'b0;
            rd_ptr_q   <= 1'b0;
            fifo_cnt_q <= 2'd0;
`ifdef MUL_MDC_OUT_TILER_LAST_EN
            last_q[0]  <= 1'b0;
            last_q[1]  <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            len_q      <= len_d;
            in_cnt_q   <= in_cnt_d;
            beat_cnt_q <= beat_cnt_d;
            err_q      <= err_d;
            mem_q[0]   <= mem_d[0];
            mem_q[1]   <= mem_d[1];
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            fifo_cnt_q <= fifo_cnt_d;
`ifdef MUL_MDC_OUT_TILER_LAST_EN
            last_q[0]  <= last_d[0];
            last_q[1]  <= last_d[1];
`endif
        end
    end

    // Next-state logic; DRAIN exit looks at post-pop counts so done follows the last beat immediately
    always_comb begin
        state_d = state_q;
        if (clear_i) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start_i) begin
                        state_d = (len_i != CNT_ZERO) ? RUN : DONE;
                    end else begin
                        state_d = IDLE;
                    end
                end
                RUN: begin
                    if (push_s && final_in_s) begin
                        state_d = DRAIN;
                    end else begin
                        state_d = RUN;
                    end
                end
                DRAIN: begin
                    if ((beat_cnt_d == len_q) && (fifo_cnt_d == 2'd0)) begin
                        state_d = DONE;
                    end else begin
                        state_d = DRAIN;
                    end
                end
                DONE:    state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    // Tile counters, length latch and sticky protocol error
    always_comb begin
        len_d      = len_q;
        in_cnt_d   = in_cnt_q;
        beat_cnt_d = beat_cnt_q;
        err_d      = err_q;
        if (clear_i) begin
            in_cnt_d   = CNT_ZERO;
            beat_cnt_d = CNT_ZERO;
            err_d      = 1'b0;
        end else if (start_i && (state_q == IDLE)) begin
            len_d      = len_i;
            in_cnt_d   = CNT_ZERO;
            beat_cnt_d = CNT_ZERO;
        end else begin
            if (start_i) begin
                err_d = 1'b1;
            end else begin
                err_d = err_q;
            end
            if (push_s) begin
                in_cnt_d = in_cnt_q + CNT_ONE;
            end else begin
                in_cnt_d = in_cnt_q;
            end
            if (pop_s) begin
                beat_cnt_d = beat_cnt_q + CNT_ONE;
            end else begin
                beat_cnt_d = beat_cnt_q;
            end
        end
    end

    // Two-entry FIFO: pointer update, occupancy and entry write
    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        fifo_cnt_d = fifo_cnt_q;
        mem_d[0]   = mem_q[0];
        mem_d[1]   = mem_q[1];
`ifdef MUL_MDC_OUT_TILER_LAST_EN
        last_d[0]  = last_q[0];
        last_d[1]  = last_q[1];
`endif
        if (clear_i) begin
            wr_ptr_d   = 1'b0;
            rd_ptr_d   = 1'b0;
            fifo_cnt_d = 2'd0;
        end else begin
            if (push_s) begin
                mem_d[wr_ptr_q] = d_i_data;
`ifdef MUL_MDC_OUT_TILER_LAST_EN
                last_d[wr_ptr_q] = final_in_s;
`endif
                wr_ptr_d = ~wr_ptr_q;
            end else begin
                wr_ptr_d = wr_ptr_q;
            end
            if (pop_s) begin
                rd_ptr_d = ~rd_ptr_q;
            end else begin
                rd_ptr_d = rd_ptr_q;
            end
            case ({push_s, pop_s})
                2'b10:   fifo_cnt_d = fifo_cnt_q + 2'd1;
                2'b01:   fifo_cnt_d = fifo_cnt_q - 2'd1;
                default: fifo_cnt_d = fifo_cnt_q;
            endcase
        end
    end

    // Output decode from registered state only
    always_comb begin
        in_ready_s  = 1'b0;
        tile_done_o = 1'b0;
        busy_o      = 1'b1;
        case (state_q)
            IDLE:    busy_o = 1'b0;
            RUN:     in_ready_s = (fifo_cnt_q < 2'd2) && (in_cnt_q < len_q);
            DRAIN:   in_ready_s = 1'b0;
            DONE:    tile_done_o = 1'b1;
            default: busy_o = 1'b0;
        endcase
        out_valid_s = (fifo_cnt_q != 2'd0);
        d_i_ready   = in_ready_s;
        d_o_valid   = out_valid_s;
        d_o_data    = mem_q[rd_ptr_q];
        beat_cnt_o  = beat_cnt_q;
        err_o       = err_q;
`ifdef MUL_MDC_OUT_TILER_LAST_EN
        last_o      = out_valid_s & last_q[rd_ptr_q];
`endif
    end

endmodule

// File: tb/tb_mul_mdc_out_tiler.sv
// Randomized scoreboard bench for mul_mdc_out_tiler; a tile-level model tracks accepted/emitted beats.
module tb_mul_mdc_out_tiler;
    localparam int DW = 32;
    localparam int CW = 16;

    logic          clk_i = 1'b0;
    logic          rst_ni, clear_i, start_i;
    logic [CW-1:0] len_i;
    logic [DW-1:0] d_i_data, d_o_data;
    logic          d_i_valid, d_i_ready, d_o_valid, d_o_ready;
    logic          tile_done_o, busy_o, err_o;
    logic [CW-1:0] beat_cnt_o;
`ifdef MUL_MDC_OUT_TILER_LAST_EN
    logic          last_o;
`endif

    mul_mdc_out_tiler #(.DATA_WIDTH(DW), .CNT_WIDTH(CW)) dut (
        .clk_i(clk_i), .rst_ni(rst_ni), .clear_i(clear_i), .start_i(start_i), .len_i(len_i),
        .d_i_data(d_i_data), .d_i_valid(d_i_valid), .d_i_ready(d_i_ready),
        .d_o_data(d_o_data), .d_o_valid(d_o_valid), .d_o_ready(d_o_ready),
        .tile_done_o(tile_done_o), .busy_o(busy_o), .beat_cnt_o(beat_cnt_o),
`ifdef MUL_MDC_OUT_TILER_LAST_EN
        .last_o(last_o),
`endif
        .err_o(err_o)
    );

    always #5 clk_i = ~clk_i;

    int            checks = 0;
    int            errors = 0;
    logic [DW-1:0] exp_q [$];
    logic [DW-1:0] src_q [$];
    int            mstate = 0;   // 0 idle, 1 tile active, 2 done cycle
    int            cur_len = 0, min_cnt = 0, mout_cnt = 0;
    logic          merr = 1'b0;
    logic          prev_stall = 1'b0;
    logic [DW-1:0] prev_data;
    logic          in_hs;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: compare every cycle against the tile model, then advance the model
    always @(negedge clk_i) begin
        int old;
        if (!rst_ni) begin
            mstate = 0; cur_len = 0; min_cnt = 0; mout_cnt = 0; merr = 1'b0;
            prev_stall = 1'b0; exp_q.delete();
        end else begin
            chk("busy", busy_o, mstate != 0);
            chk("tile_done", tile_done_o, mstate == 2);
            chk("beat_cnt", beat_cnt_o, mout_cnt);
            chk("err", err_o, merr);
            chk("d_i_ready", d_i_ready, (mstate == 1) && (min_cnt < cur_len) && (min_cnt - mout_cnt < 2));
            chk("d_o_valid", d_o_valid, (mstate != 0) && (min_cnt > mout_cnt));
`ifdef MUL_MDC_OUT_TILER_LAST_EN
            chk("last_o", last_o, (mstate != 0) && (min_cnt > mout_cnt) && (mout_cnt == cur_len - 1));
`endif
            if (prev_stall) chk("d_o_stable", d_o_data, prev_data);
            prev_stall = d_o_valid && !d_o_ready;
            prev_data  = d_o_data;
            if (clear_i) begin
                mstate = 0; min_cnt = 0; mout_cnt = 0; merr = 1'b0;
                prev_stall = 1'b0; exp_q.delete();
            end else begin
                old = mstate;
                if (d_i_valid && d_i_ready) min_cnt++;
                if (d_o_valid && d_o_ready) begin
                    if (exp_q.size() == 0) chk("unexpected_beat", 64'd1, 64'd0);
                    else chk("d_o_data", d_o_data, exp_q.pop_front());
                    mout_cnt++;
                    if (old == 1 && mout_cnt == cur_len) mstate = 2;
                end
                if (start_i) begin
                    if (old == 0) begin
                        cur_len = int'(len_i); min_cnt = 0; mout_cnt = 0;
                        mstate = (len_i == 0) ? 2 : 1;
                    end else begin
                        merr = 1'b1;
                    end
                end
                if (old == 2) mstate = 0;
            end
        end
    end

    task automatic cyc();
        @(negedge clk_i);
        in_hs = d_i_valid && d_i_ready;
        @(posedge clk_i);
        #1;
        if (in_hs) begin
            void'(src_q.pop_front());
            d_i_valid = 1'b0;
        end
    endtask

    task automatic check_reset_outputs();
        chk("rst_d_o_valid", d_o_valid, 64'd0);
        chk("rst_d_i_ready", d_i_ready, 64'd0);
        chk("rst_tile_done", tile_done_o, 64'd0);
        chk("rst_busy", busy_o, 64'd0);
        chk("rst_beat_cnt", beat_cnt_o, 64'd0);
        chk("rst_err", err_o, 64'd0);
`ifdef MUL_MDC_OUT_TILER_LAST_EN
        chk("rst_last", last_o, 64'd0);
`endif
    endtask

    // mode: 0 random ready, 1 ready high, 2 ready low 5 cycles; inject: 1 stray start, 2 clear, 4 reset
    task automatic run_tile(input int len, input int mode, input int inject);
        logic [DW-1:0] w;
        start_i = 1'b1;
        len_i   = CW'(len);
        for (int i = 0; i < len; i++) begin
            w = $urandom;
            exp_q.push_back(w);
            src_q.push_back(w);
        end
        cyc();
        start_i = 1'b0;
        for (int c = 0; c < 400 && mstate != 0; c++) begin
            case (mode)
                1:       d_o_ready = 1'b1;
                2:       d_o_ready = (c >= 5);
                default: d_o_ready = ($urandom_range(0, 3) != 0);
            endcase
            if (!d_i_valid && src_q.size() > 0 && (mode != 0 || $urandom_range(0, 3) != 0)) begin
                d_i_valid = 1'b1;
                d_i_data  = src_q[0];
            end
            if ((inject & 1) != 0 && mstate == 1 && (c == 1 || $urandom_range(0, 15) == 0)) begin
                start_i = 1'b1;
                len_i   = CW'(8);
            end
            if ((inject & 2) != 0 && mstate == 1 && mout_cnt >= 2) begin
                clear_i = 1'b1; d_o_ready = 1'b0; d_i_valid = 1'b0; start_i = 1'b0;
                cyc();
                clear_i = 1'b0;
                src_q.delete();
            end else if ((inject & 4) != 0 && mstate == 1 && mout_cnt >= 2) begin
                rst_ni = 1'b0; d_o_ready = 1'b0; d_i_valid = 1'b0; start_i = 1'b0;
                #1;
                check_reset_outputs();
                @(negedge clk_i);
                @(posedge clk_i);
                #1;
                rst_ni = 1'b1;
                src_q.delete();
            end else begin
                cyc();
                start_i = 1'b0;
            end
        end
        if (mstate != 0) chk("tile_timeout", 64'd1, 64'd0);
    endtask

    task automatic do_clear();
        clear_i = 1'b1;
        cyc();
        clear_i = 1'b0;
    endtask

    initial begin
        rst_ni = 1'b0; clear_i = 1'b0; start_i = 1'b0; len_i = '0;
        d_i_data = '0; d_i_valid = 1'b0; d_o_ready = 1'b0;
        repeat (3) @(posedge clk_i);
        #1;
        check_reset_outputs();
        rst_ni = 1'b1;
        @(posedge clk_i);
        #1;
        run_tile(4, 1, 0);
        run_tile(3, 2, 0);
        run_tile(0, 0, 0);
        run_tile(1, 1, 0);
        run_tile(5, 1, 1);
        do_clear();
        run_tile(6, 1, 2);
        run_tile(2, 1, 0);
        run_tile(6, 1, 4);
        run_tile(2, 1, 0);
        for (int t = 0; t < 60; t++) begin
            run_tile($urandom_range(0, 7), 0, ($urandom_range(0, 3) == 0) ? 1 : 0);
            if ($urandom_range(0, 5) == 0) do_clear();
        end
        run_tile(7, 0, 2);
        repeat (3) cyc();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
